// File: rtl/arith_encoder_pkg.sv
// Shared widths, scheduler states and the buffered symbol tuple for the arithmetic encoder front end.
package arith_encoder_pkg;

  localparam int RANGE_W = 16;
  localparam int LOW_W   = 24;
  localparam int SYM_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [RANGE_W-1:0] fl;
    logic [RANGE_W-1:0] fh;
    logic [SYM_W-1:0]   symbol;
    logic [SYM_W:0]     nsyms;
    logic               last;
  } sym_tuple_t;

endpackage

// File: rtl/arith_input_fifo.sv
// Registered tuple FIFO: a push is visible at the head one cycle later, no bypass.
// Pushes while full and pops while empty are ignored; extra pointer MSB tells full from empty.
module arith_input_fifo
  import arith_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  sym_tuple_t i_push_dat,
  input  logic       i_pop,
  output sym_tuple_t o_pop_dat,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  sym_tuple_t     r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_wr_en;
  logic           w_rd_en;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en   = i_push && !o_full;
  assign w_rd_en   = i_pop && !o_empty;
  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/arith_encoder_scheduler.sv
// Frame sequencer for the arithmetic encoder: buffers tuples, issues one per cycle, tags results.
// Issue lands on enc_* one cycle after pop; results return PIPE_LATENCY+1 cycles after enc_valid.
module arith_encoder_scheduler
  import arith_encoder_pkg::*;
#(
  parameter int RANGE_WIDTH  = RANGE_W,
  parameter int LOW_WIDTH    = LOW_W,
  parameter int SYMBOL_WIDTH = SYM_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int PIPE_LATENCY = 2
) (
  input  logic                    general_clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_last,
  output logic                    enc_init,
  output logic                    enc_valid,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  input  logic [RANGE_WIDTH-1:0]  enc_range,
  input  logic [LOW_WIDTH-1:0]    enc_low,
  output logic                    res_valid,
  output logic [RANGE_WIDTH-1:0]  res_range,
  output logic [LOW_WIDTH-1:0]    res_low,
  output logic                    res_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             sym_count
);

  state_t                  r_state;
  state_t                  w_next;
  sym_tuple_t              w_push_dat;
  sym_tuple_t              w_pop_dat;
  sym_tuple_t              r_enc;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    r_last_acc;
  logic                    r_enc_vld;
  logic [15:0]             r_sym_cnt;
  logic [PIPE_LATENCY-1:0] r_tag_vld;
  logic [PIPE_LATENCY-1:0] r_tag_last;
  logic                    r_res_vld;
  logic                    r_res_last;
  logic [RANGE_WIDTH-1:0]  r_res_range;
  logic [LOW_WIDTH-1:0]    r_res_low;

  assign w_push_dat = '{fl: in_fl, fh: in_fh, symbol: in_symbol, nsyms: in_nsyms, last: in_last};
  // Once the frame's last tuple is in, upstream is held off until the next INIT.
  assign in_ready   = ((r_state == ST_INIT) || (r_state == ST_RUN)) && !w_fifo_full && !r_last_acc;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == ST_RUN) && !w_fifo_empty;

  arith_input_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (general_clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_pop_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (frame_start) w_next = ST_INIT;
      ST_INIT:  w_next = ST_RUN;
      ST_RUN:   if (w_pop && w_pop_dat.last) w_next = ST_DRAIN;
      ST_DRAIN: if (r_res_vld && r_res_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_last_acc <= 1'b0;
      r_enc_vld  <= 1'b0;
      r_enc      <= '0;
      r_sym_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_enc_vld <= w_pop;
      if (w_pop) r_enc <= w_pop_dat;
      if ((r_state == ST_IDLE) && frame_start) r_last_acc <= 1'b0;
      else if (w_push && in_last)              r_last_acc <= 1'b1;
      if (r_state == ST_INIT)                  r_sym_cnt <= '0;
      else if (w_pop && (r_sym_cnt != 16'hFFFF)) r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  // Tag pipe mirrors the encoder latency so the capture lines up with each issued symbol.
  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld   <= '0;
      r_tag_last  <= '0;
      r_res_vld   <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_range <= '0;
      r_res_low   <= '0;
    end else begin
      r_tag_vld[0]  <= r_enc_vld;
      r_tag_last[0] <= r_enc_vld && r_enc.last;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
      r_res_vld  <= r_tag_vld[PIPE_LATENCY-1];
      r_res_last <= r_tag_vld[PIPE_LATENCY-1] && r_tag_last[PIPE_LATENCY-1];
      if (r_tag_vld[PIPE_LATENCY-1]) begin
        r_res_range <= enc_range;
        r_res_low   <= enc_low;
      end
    end
  end

  assign enc_init   = (r_state == ST_INIT);
  assign enc_valid  = r_enc_vld;
  assign enc_fl     = r_enc.fl;
  assign enc_fh     = r_enc.fh;
  assign enc_symbol = r_enc.symbol;
  assign enc_nsyms  = r_enc.nsyms;
  assign res_valid  = r_res_vld;
  assign res_range  = r_res_range;
  assign res_low    = r_res_low;
  assign res_last   = r_res_last;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign sym_count  = r_sym_cnt;

endmodule
